// File: rtl/packet_trigger_detector.sv
// Packet trigger detector: qualifies envelope energy, skips the PLCP
// preamble, then fires a fixed-width trigger to the translator.
module packet_trigger_detector #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 40,
  parameter int TRIG_DELAY  = 1920,
  parameter int TRIG_WIDTH  = 8,
  parameter int DROP_TOL    = 4,
  parameter int HOLDOFF     = 100,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             env_in,
  output logic             trigger_signal,
  output logic             busy,
  output logic [CNT_W-1:0] trig_count,
  output logic [CNT_W-1:0] abort_count
);

  localparam int RW = $clog2(MIN_HIGH + 1);
  localparam int DW = $clog2(TRIG_DELAY + 1);
  localparam int FW = $clog2(TRIG_WIDTH + 1);
  localparam int LMAX =
    (DROP_TOL > HOLDOFF) ? DROP_TOL : HOLDOFF;
  localparam int LW = $clog2(LMAX + 1);

  localparam logic [RW-1:0] RUN_QUAL = RW'(MIN_HIGH);
  localparam logic [DW-1:0] DLY_LAST = DW'(TRIG_DELAY - 1);
  localparam logic [FW-1:0] WID_LAST = FW'(TRIG_WIDTH - 1);
  localparam logic [LW-1:0] DROP_LIM = LW'(DROP_TOL);
  localparam logic [LW-1:0] HOLD_LIM = LW'(HOLDOFF);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUAL,
    S_DELAY,
    S_FIRE,
    S_HOLD
  } state_t;

  state_t state_q;
  state_t state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   env_s;

  logic [RW-1:0] run_q;
  logic [RW-1:0] run_n;
  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] dcnt_n;
  logic [FW-1:0] fcnt_q;
  logic [FW-1:0] fcnt_n;
  logic [LW-1:0] lowrun_q;
  logic [LW-1:0] lowrun_n;
  logic [LW-1:0] low_nx;

  logic trig_inc;
  logic abort_inc;

  // env_in is asynchronous; nothing but this chain may sample it
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], env_in};
    end
  end

  assign env_s = sync_q[SYNC_STAGES-1];

  assign low_nx = env_s ? '0 : lowrun_q + LW'(1);

  always_comb begin
    state_n   = state_q;
    run_n     = run_q;
    dcnt_n    = dcnt_q;
    fcnt_n    = fcnt_q;
    lowrun_n  = lowrun_q;
    trig_inc  = 1'b0;
    abort_inc = 1'b0;
    if (!enable) begin
      state_n  = S_IDLE;
      run_n    = '0;
      dcnt_n   = '0;
      fcnt_n   = '0;
      lowrun_n = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (env_s) begin
            state_n = S_QUAL;
            run_n   = RW'(1);
          end
        end
        S_QUAL: begin
          // MIN_HIGH high samples already seen, counting the IDLE one
          if (run_q == RUN_QUAL) begin
            state_n  = S_DELAY;
            dcnt_n   = '0;
            lowrun_n = '0;
          end else if (!env_s) begin
            state_n = S_IDLE;
          end else begin
            run_n = run_q + RW'(1);
          end
        end
        S_DELAY: begin
          lowrun_n = low_nx;
          if (low_nx == DROP_LIM) begin
            state_n   = S_IDLE;
            abort_inc = 1'b1;
          end else if (dcnt_q == DLY_LAST) begin
            state_n  = S_FIRE;
            fcnt_n   = '0;
            trig_inc = 1'b1;
          end else begin
            dcnt_n = dcnt_q + DW'(1);
          end
        end
        S_FIRE: begin
          if (fcnt_q == WID_LAST) begin
            state_n  = S_HOLD;
            lowrun_n = '0;
          end else begin
            fcnt_n = fcnt_q + FW'(1);
          end
        end
        S_HOLD: begin
          lowrun_n = low_nx;
          if (low_nx == HOLD_LIM) begin
            state_n = S_IDLE;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      run_q    <= '0;
      dcnt_q   <= '0;
      fcnt_q   <= '0;
      lowrun_q <= '0;
    end else begin
      state_q  <= state_n;
      run_q    <= run_n;
      dcnt_q   <= dcnt_n;
      fcnt_q   <= fcnt_n;
      lowrun_q <= lowrun_n;
    end
  end

  // outputs decoded from next state so they leave a flop directly
  always_ff @(posedge clock) begin
    if (reset) begin
      trigger_signal <= 1'b0;
      busy           <= 1'b0;
    end else begin
      trigger_signal <= (state_n == S_FIRE);
      busy           <= (state_n != S_IDLE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      trig_count  <= '0;
      abort_count <= '0;
    end else begin
      if (trig_inc && trig_count != CNT_MAX) begin
        trig_count <= trig_count + CNT_W'(1);
      end
      if (abort_inc && abort_count != CNT_MAX) begin
        abort_count <= abort_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_packet_trigger_detector.sv
// Bench for packet_trigger_detector: directed packet scenarios plus
// random envelope traffic against a timestamp-based reference model.
module tb_packet_trigger_detector;

  localparam int SYNC = 2;
  localparam int MINH = 4;
  localparam int TDLY = 10;
  localparam int TWID = 3;
  localparam int DROP = 2;
  localparam int HOLD = 5;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  localparam int P_IDLE  = 0;
  localparam int P_QUAL  = 1;
  localparam int P_DELAY = 2;
  localparam int P_FIRE  = 3;
  localparam int P_HOLD  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          env;
  logic          trig;
  logic          busy;
  logic [CW-1:0] tcnt;
  logic [CW-1:0] acnt;

  packet_trigger_detector #(
    .SYNC_STAGES(SYNC),
    .MIN_HIGH   (MINH),
    .TRIG_DELAY (TDLY),
    .TRIG_WIDTH (TWID),
    .DROP_TOL   (DROP),
    .HOLDOFF    (HOLD),
    .CNT_W      (CW)
  ) dut (
    .clock         (clk),
    .reset         (rst),
    .enable        (en),
    .env_in        (env),
    .trigger_signal(trig),
    .busy          (busy),
    .trig_count    (tcnt),
    .abort_count   (acnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  // reference model: timestamps of phase entry and a trailing-low count
  int cyc = 0;
  int ph = P_IDLE;
  int qs, ds, fs, hs;
  int lowtr = 0;
  int m_tc = 0;
  int m_ac = 0;
  bit m_trig = 1'b0;
  bit m_busy = 1'b0;
  logic [SYNC-1:0] m_sh = '0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge clk) begin
    bit es;
    cyc++;
    es = m_sh[SYNC-1];
    if (rst) begin
      m_sh = '0;
      ph   = P_IDLE;
      m_tc = 0;
      m_ac = 0;
    end else begin
      m_sh  = {m_sh[SYNC-2:0], env};
      lowtr = es ? 0 : lowtr + 1;
      if (!en) begin
        ph = P_IDLE;
      end else begin
        case (ph)
          P_IDLE: if (es) begin
            ph = P_QUAL;
            qs = cyc;
          end
          P_QUAL: begin
            if (cyc - qs == MINH) begin
              ph = P_DELAY;
              ds = cyc;
            end else if (!es) begin
              ph = P_IDLE;
            end
          end
          P_DELAY: begin
            if (imin(lowtr, cyc - ds) >= DROP) begin
              ph = P_IDLE;
              if (m_ac < CMAX) m_ac++;
            end else if (cyc - ds == TDLY) begin
              ph = P_FIRE;
              fs = cyc;
              if (m_tc < CMAX) m_tc++;
            end
          end
          P_FIRE: begin
            if (cyc - fs == TWID) begin
              ph = P_HOLD;
              hs = cyc;
            end
          end
          default: begin
            if (imin(lowtr, cyc - hs) >= HOLD) ph = P_IDLE;
          end
        endcase
      end
    end
    m_trig = (ph == P_FIRE);
    m_busy = (ph != P_IDLE);
  end

  // per-cycle comparison and directed-scenario measurements
  int hi_cnt = 0;
  int rise_at = -1;
  int fall_at = -1;
  bit prev_trig = 1'b0;
  bit prev_busy = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("trig", 32'(trig), 32'(m_trig));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("tcnt", 32'(tcnt), 32'(m_tc));
      chk("acnt", 32'(acnt), 32'(m_ac));
    end
    if (trig === 1'b1) begin
      hi_cnt++;
      if (!prev_trig) rise_at = cyc;
    end
    if (busy === 1'b0 && prev_busy) fall_at = cyc;
    prev_trig = (trig === 1'b1);
    prev_busy = (busy === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    env = 1'b0;
    en  = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    hi_cnt  = 0;
    rise_at = -1;
    fall_at = -1;
  endtask

  task automatic pkt(input int hi, input int lo);
    env = 1'b1;
    tick(hi);
    env = 1'b0;
    tick(lo);
  endtask

  int t0;
  int tl;

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    env = 1'b0;
    tick(3);
    chk_on = 1'b1;
    rst = 1'b0;
    tick(1);
    chk("rst_trig", 32'(trig), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tcnt", 32'(tcnt), 0);
    chk("rst_acnt", 32'(acnt), 0);

    // clean packet
    do_reset();
    t0 = cyc + 1;
    env = 1'b1;
    tick(40);
    tl = cyc + 1;
    env = 1'b0;
    tick(20);
    chk("clean_lat", 32'(rise_at - t0), 16);
    chk("clean_width", 32'(hi_cnt), TWID);
    chk("clean_tcnt", 32'(tcnt), 1);
    chk("clean_acnt", 32'(acnt), 0);
    chk("clean_busy_end", 32'(fall_at - tl), 6);

    // short burst
    do_reset();
    env = 1'b1;
    tick(3);
    env = 1'b0;
    tick(3);
    chk("short_busy", 32'(busy), 0);
    tick(5);
    chk("short_trig", 32'(hi_cnt), 0);
    chk("short_tcnt", 32'(tcnt), 0);

    // two-cycle gap early in DELAY
    do_reset();
    pkt(7, 2);
    env = 1'b1;
    tick(2);
    chk("gap2_busy", 32'(busy), 0);
    chk("gap2_acnt", 32'(acnt), 1);
    env = 1'b0;
    tick(10);
    chk("gap2_trig", 32'(hi_cnt), 0);
    chk("gap2_tcnt", 32'(tcnt), 0);

    // one-cycle gap is tolerated
    do_reset();
    t0 = cyc + 1;
    pkt(7, 1);
    pkt(30, 20);
    chk("gap1_lat", 32'(rise_at - t0), 16);
    chk("gap1_tcnt", 32'(tcnt), 1);
    chk("gap1_acnt", 32'(acnt), 0);

    // long packet held off, then a fresh one accepted
    do_reset();
    env = 1'b1;
    tick(119);
    chk("hold_once", 32'(hi_cnt), TWID);
    pkt(0, 4);
    env = 1'b1;
    tick(10);
    chk("hold_busy", 32'(busy), 1);
    chk("hold_tcnt", 32'(tcnt), 1);
    env = 1'b0;
    tick(8);
    chk("hold_end", 32'(busy), 0);
    pkt(40, 20);
    chk("hold_next", 32'(tcnt), 2);

    // enable dropped mid-pulse
    do_reset();
    env = 1'b1;
    for (int i = 0; i < 40 && trig !== 1'b1; i++) tick(1);
    chk("fire_seen", 32'(trig), 1);
    en  = 1'b0;
    env = 1'b0;
    tick(1);
    chk("en_trig", 32'(trig), 0);
    chk("en_busy", 32'(busy), 0);
    chk("en_tcnt", 32'(tcnt), 1);
    chk("en_acnt", 32'(acnt), 0);
    en = 1'b1;
    tick(10);

    // reset while in DELAY
    do_reset();
    pkt(40, 20);
    env = 1'b1;
    tick(10);
    chk("dly_busy", 32'(busy), 1);
    rst = 1'b1;
    tick(1);
    chk("rstd_trig", 32'(trig), 0);
    chk("rstd_busy", 32'(busy), 0);
    chk("rstd_tcnt", 32'(tcnt), 0);
    chk("rstd_acnt", 32'(acnt), 0);
    rst = 1'b0;
    env = 1'b0;
    tick(5);

    // saturation of both counters
    do_reset();
    repeat (20) pkt(40, 20);
    chk("sat_tcnt", 32'(tcnt), CMAX);
    chk("sat_pulses", 32'(hi_cnt), 20 * TWID);
    do_reset();
    repeat (17) pkt(7, 8);
    chk("sat_acnt", 32'(acnt), CMAX);

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      r   = $urandom_range(0, 29);
      en  = (r != 0);
      rst = (r == 1);
      env = 1'($urandom_range(0, 1));
      if (env) tick($urandom_range(1, 60));
      else tick($urandom_range(1, 8));
    end
    rst = 1'b0;
    en  = 1'b1;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
